// File: rtl/fetcher_pkg.sv
// Shared types for the instruction-fetch stage: word types, the IF/ID
// pipeline register, the fetch FSM encoding and small helpers.
package fetcher_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    // Pipeline register handed from fetch to decode.
    typedef struct packed {
        logic valid;
        u64   pc;
        u64   pcPlus4;
        u32   instr;
        u64   instrAddr;
    } REG_IF_ID;

    // FETCH: live request for pc outstanding.
    // HOLD : instruction captured in ibuf, waiting for the pipeline to move.
    // DROP : stale request outstanding; its response is thrown away.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } FETCH_STATE_T;

    localparam u64 INSTR_BYTES = 64'd4;

    // Force a byte address onto a 32-bit instruction boundary.
    function automatic u64 align_word(input u64 addr);
        return addr & ~64'h0000_0000_0000_0003;
    endfunction

    // Build a valid IF/ID entry for the instruction fetched from addr.
    function automatic REG_IF_ID make_if_id(input u64 addr, input u32 instr);
        REG_IF_ID r;
        r.valid     = 1'b1;
        r.pc        = addr;
        r.pcPlus4   = addr + INSTR_BYTES;
        r.instr     = instr;
        r.instrAddr = addr;
        return r;
    endfunction

endpackage

// File: rtl/fetcher_if.sv
// Instruction bus between the fetch stage (master) and instruction memory
// (slave). One request outstanding at a time; iresp_data_ok completes it.
interface fetcher_if;
    import fetcher_pkg::*;

    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_data_ok;
    u32   iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetcher.sv
// Instruction-fetch stage: owns the PC, keeps one word read in flight on the
// instruction bus and fills the IF/ID register when the pipeline advances.
// A redirect that lands while a read is in flight parks the FSM in DROP until
// that read completes, so the stale word never reaches decode.
module fetcher
    import fetcher_pkg::*;
#(
    parameter u64 RESET_PC = 64'h8000_0000
) (
    input  logic      clk,
    input  logic      rst,
    fetcher_if.master bus,
    input  logic      redirect_valid,
    input  u64        redirect_pc,
    output REG_IF_ID  moduleOut,
    output logic      ok_to_proceed,
    input  logic      ok_to_proceed_overall
);

    FETCH_STATE_T state_r, state_s;
    u64           pc_r, pc_s;
    u64           req_addr_r, req_addr_s;
    u32           ibuf_r, ibuf_s;
    REG_IF_ID     out_r, out_s;

    logic         resp_s;
    logic         ready_s;
    u32           instr_s;
    u64           target_s;

    assign resp_s   = bus.iresp_data_ok;
    assign target_s = align_word(redirect_pc);

    // Ready when a word is buffered or arriving on the bus right now.
    assign ready_s = (state_r == HOLD) || ((state_r == FETCH) && resp_s);
    assign instr_s = ((state_r == FETCH) && resp_s) ? bus.iresp_data : ibuf_r;

    assign ok_to_proceed  = ready_s;
    assign bus.ireq_valid = ((state_r == FETCH) || (state_r == DROP)) && !rst;
    assign bus.ireq_addr  = req_addr_r;
    assign moduleOut      = out_r;

    // Next-state, PC, buffer and IF/ID selection; redirect takes priority.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        req_addr_s = req_addr_r;
        ibuf_s     = ibuf_r;
        out_s      = out_r;

        if (redirect_valid) begin
            pc_s        = target_s;
            out_s.valid = 1'b0;
            if (((state_r == FETCH) || (state_r == DROP)) && !resp_s) begin
                // Read still in flight: wait for it, keep its address on the bus.
                state_s = DROP;
            end else begin
                req_addr_s = target_s;
                state_s    = FETCH;
            end
        end else if (ok_to_proceed_overall && ready_s) begin
            out_s      = make_if_id(req_addr_r, instr_s);
            pc_s       = req_addr_r + INSTR_BYTES;
            req_addr_s = req_addr_r + INSTR_BYTES;
            state_s    = FETCH;
        end else begin
            // Pipeline moving with nothing from us: insert a bubble.
            if (ok_to_proceed_overall) begin
                out_s.valid = 1'b0;
            end else begin
                out_s.valid = out_r.valid;
            end

            case (state_r)
                FETCH: begin
                    if (resp_s) begin
                        ibuf_s  = bus.iresp_data;
                        state_s = HOLD;
                    end else begin
                        state_s = FETCH;
                    end
                end
                HOLD: begin
                    state_s = HOLD;
                end
                DROP: begin
                    if (resp_s) begin
                        req_addr_s = pc_r;
                        state_s    = FETCH;
                    end else begin
                        state_s = DROP;
                    end
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end
    end

    // State register with synchronous reset; responses during reset are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            ibuf_r     <= 32'h0000_0000;
            out_r      <= '0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_addr_r <= req_addr_s;
            ibuf_r     <= ibuf_s;
            out_r      <= out_s;
        end
    end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction-fetch stage of the five-stage RV64 pipeline: owns the architectural PC, issues word reads on the instruction bus, and produces the `REG_IF_ID` register consumed by the decode stage. It joins the global stall handshake: it reports readiness on `ok_to_proceed` and advances only when the pipeline-wide `ok_to_proceed_overall` is high. Branch and jump redirects from execute replace the PC. Any fetch still in flight on the bus at redirect time is completed and its data discarded.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC loaded on reset.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `ireq_valid`  out  1: instruction read request.
- `ireq_addr`  out  64: request byte address, word aligned.
- `iresp_data_ok`  in  1: response valid this cycle; completes the outstanding request.
- `iresp_data`  in  32: instruction word; valid when `iresp_data_ok` is high.
- `redirect_valid`  in  1: execute redirects the PC. Only asserted in cycles where `ok_to_proceed_overall` is 1.
- `redirect_pc`  in  64: redirect target; bits [1:0] are ignored (treated as 0).
- `moduleOut`  out  `REG_IF_ID`: fields `valid`, `pc`, `pcPlus4`, `instr`, `instrAddr`.
- `ok_to_proceed`  out  1: this stage has an instruction ready this cycle.
- `ok_to_proceed_overall`  in  1: AND of all stage readies; the pipeline advances this cycle.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: address of the outstanding request.
  - `ibuf`: buffered instruction.
  - `state`: FSM state.
- FSM states:
  - **FETCH**: request outstanding for `pc`.
  - **HOLD**: instruction in `ibuf`, waiting to advance.
  - **DROP**: stale request outstanding; its response will be discarded.
- `ireq_valid` = (state == FETCH or DROP) and not `rst`.
- `ireq_addr` = `req_addr`. It stays stable from the cycle `ireq_valid` rises until the cycle of `iresp_data_ok`.
- `ok_to_proceed` = (state == HOLD) or (state == FETCH and `iresp_data_ok`). This is combinational.
- Instruction source for this cycle: `iresp_data` when in FETCH with `iresp_data_ok`, else `ibuf`.
- FETCH transitions:
  - `iresp_data_ok` and overall high: load `moduleOut` with `valid`=1, `pc`=`instrAddr`=`req_addr`, `pcPlus4`=`req_addr`+4, `instr`=`iresp_data`. Set `pc` and `req_addr` to `req_addr`+4. Stay in FETCH.
  - `iresp_data_ok` and overall low: `ibuf` <= `iresp_data`; go to HOLD.
  - No response: stay in FETCH.
- HOLD transitions:
  - Overall high: load `moduleOut` from `ibuf` and `req_addr`, as above. Advance `pc` and `req_addr` by 4; go to FETCH.
  - Overall low: stay in HOLD.
- DROP transitions:
  - `iresp_data_ok`: discard the data. `req_addr` <= `pc`; go to FETCH.
  - Otherwise: stay in DROP.
- Overall high with nothing ready (only possible when ready is masked during a flush): load `moduleOut.valid` = 0.
- Overall low: `moduleOut` holds all fields.
- Redirect (overrides all other rules):
  - Next `pc` = `{redirect_pc[63:2], 2'b00}`.
  - `moduleOut.valid` <= 0.
  - If in FETCH with no `iresp_data_ok`, or in DROP with no `iresp_data_ok`: go to DROP; `req_addr` unchanged.
  - Otherwise: `req_addr` <= new `pc`; go to FETCH. Any response in this cycle is discarded and `ibuf` is ignored.
- Arithmetic is 64-bit wrap-around: `pc` 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. No fault is raised.

## Timing
- Reset values:
  - `state` = FETCH; `pc` = `req_addr` = `RESET_PC`.
  - `moduleOut` = all fields 0 (`valid` = 0); `ibuf` = 0.
  - `ireq_valid` = 0 while `rst` is high, and 1 in the first cycle after.
- Latency: a response arriving in cycle N with overall high makes `moduleOut` valid in cycle N+1.
- Throughput: one instruction per cycle when the bus answers in the same cycle it is requested.
- Redirect in cycle N:
  - `moduleOut.valid` = 0 in N+1.
  - With no outstanding request, the first request to the target is issued in N+1.
  - With an outstanding request, the target request is issued the cycle after the stale `iresp_data_ok`.
- Reset asserted mid-request: all state is reinitialised. A response arriving during reset is ignored, and the bus is assumed reset by the same `rst`.
- `ok_to_proceed` has a combinational path from `iresp_data_ok`. `ok_to_proceed_overall` must not depend combinationally on `ireq_valid`.

## Structure
- Shared package `common`:
  - `REG_IF_ID` (existing), `u64`, `u32`.
  - New enum `FETCH_STATE_T` {`FETCH`, `HOLD`, `DROP`}.
  - `IBUS_REQ`/`IBUS_RESP` structs if the bus is bundled.
- Single module; no sub-module is warranted. The FSM, PC and buffer are inline (about 150 lines).

## Test plan
- Reset with `RESET_PC` = 64'h8000_0000, bus responding same cycle, overall held 1: `ireq_addr` reads 8000_0000, _0004, _0008 on consecutive cycles. `moduleOut` follows one cycle later with `pcPlus4` = pc+4.
- Bus response delayed 3 cycles: `ok_to_proceed` = 0 for 3 cycles, then 1 on the `iresp_data_ok` cycle. `ireq_addr` is stable throughout.
- Response arrives with overall = 0 for 2 cycles: state HOLD, `moduleOut` unchanged. On overall = 1, `moduleOut.instr` equals the buffered word and the next request is issued at +4.
- Redirect to 64'h8000_0102 while a fetch of 8000_0010 is outstanding: state DROP, the 8000_0010 response is discarded, next request is at 8000_0100, and `moduleOut.valid` = 0 in the interim.
- Redirect in the same cycle as `iresp_data_ok` in FETCH: response discarded; request at the target is issued the next cycle.
- `rst` asserted for one cycle while in DROP: returns to FETCH at `RESET_PC`, `moduleOut.valid` = 0. A late response during reset has no effect.
